// File: rtl/arm_instr_encoder.sv
// Packs ARM instruction fields into 32-bit words and streams them into sequential imem slots.
// Encodings the single-cycle decoder cannot execute are rejected with a one-cycle err pulse.
module arm_instr_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        cond,
  input  logic [1:0]        op,
  input  logic [5:0]        funct,
  input  logic [3:0]        rn,
  input  logic [3:0]        rd,
  input  logic [11:0]       src2,
  input  logic [23:0]       imm24,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W:0] CAP = (ADDR_W+1)'(1) << ADDR_W;

  typedef enum logic [1:0] {IDLE, WRITE, FULL_ST} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W:0]     count_reg, count_next;
  logic                mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
  logic [31:0]         mem_wdata_reg, mem_wdata_next;
  logic                err_reg, err_next;
  logic                legal;
  logic [31:0]         enc_word;
  logic                hs;

  // Only the data-processing commands the decoder implements are legal; CMP must set flags.
  always_comb begin
    legal = 1'b1;
    case (op)
      2'b11: legal = 1'b0;
      2'b00: begin
        case (funct[4:1])
          4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1101: legal = 1'b1;
          4'b1010: legal = funct[0];
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b1;
    endcase
  end

  assign enc_word = (op == 2'b10) ? {cond, 2'b10, funct[5:4], imm24}
                                  : {cond, op, funct, rn, rd, src2};

  // clear takes priority over a handshake, so the encoder refuses input that cycle.
  assign in_ready = (state_reg == IDLE) && !clear;
  assign hs       = in_valid && in_ready;

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    mem_we_next    = 1'b0;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    err_next       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (clear) begin
          count_next = '0;
        end else if (hs && legal) begin
          state_next     = WRITE;
          mem_we_next    = 1'b1;
          mem_addr_next  = count_reg[ADDR_W-1:0];
          mem_wdata_next = enc_word;
        end else if (hs) begin
          err_next = 1'b1;
        end
      end
      WRITE: begin
        count_next = count_reg + (ADDR_W+1)'(1);
        state_next = (count_next == CAP) ? FULL_ST : IDLE;
      end
      FULL_ST: begin
        if (clear) begin
          count_next = '0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      err_reg       <= err_next;
    end
  end

  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign count     = count_reg;
  assign full      = (count_reg == CAP);
  assign err       = err_reg;

endmodule
